// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the sequential 16/8 restoring divider:
//               default operand width, FSM state encoding and result
//               constants used for exception results.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Divisor / quotient / remainder width; the dividend is twice this wide.
    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Result constants at the default width (saturated quotient, zero).
    localparam logic [DIV_WIDTH-1:0] c_quot_sat = {DIV_WIDTH{1'b1}};
    localparam logic [DIV_WIDTH-1:0] c_zero     = {DIV_WIDTH{1'b0}};

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_fa.sv
`default_nettype none
// ============================================================================
// Module      : div_fa
// Description : Single-bit full adder cell, shared with the multiplier array.
// Ports       : i_a, i_b, i_ci -> o_s (sum), o_co (carry out)
// Revision    : 1.0 - initial release
// ============================================================================
module div_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule : div_fa
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// ============================================================================
// Module      : div_restore_step
// Description : Combinational (WIDTH+1)-bit compare-subtract for one restoring
//               division step. Computes i_a - i_b as i_a + ~i_b + 1 through a
//               ripple chain of full-adder cells.
// Ports       : i_a    [WIDTH:0]   partial remainder with next dividend bit
//               i_b    [WIDTH:0]   zero-extended divisor
//               o_diff [WIDTH-1:0] low bits of i_a - i_b
//               o_ge   1           i_a >= i_b (final carry out, no borrow)
// Revision    : 1.0 - initial release
// ============================================================================
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH:0]   i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_ge
);

    // w_carry[0] = 1 supplies the +1 of the two's-complement subtraction.
    logic [WIDTH+1:0] w_carry;
    logic [WIDTH:0]   w_sum;
    // The difference MSB is only ever consumed when o_ge is set, and then the
    // caller keeps its remainder below the divisor, so that bit is always 0.
    logic             w_unused_msb;

    assign w_carry[0] = 1'b1;

    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_fa
        div_fa u_fa (
            .i_a  (i_a[gi]),
            .i_b  (~i_b[gi]),
            .i_ci (w_carry[gi]),
            .o_s  (w_sum[gi]),
            .o_co (w_carry[gi+1])
        );
    end : g_fa

    assign o_diff       = w_sum[WIDTH-1:0];
    assign w_unused_msb = w_sum[WIDTH];
    assign o_ge         = w_carry[WIDTH+1];

endmodule : div_restore_step
`default_nettype wire

// File: rtl/div_16by8_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_16by8_seq
// Description : Sequential restoring divider, 2*WIDTH / WIDTH bits, one
//               quotient bit per clock under a start/ready/done handshake.
//               Divide-by-zero and quotient overflow finish in one cycle.
// Ports       : clk, rst_n (async, active low)
//               start, dividend[2W], divisor[W]        - request
//               ready, done                            - handshake
//               quotient[W], remainder[W]              - held results
//               div_by_zero, overflow                  - held flags
// Revision    : 1.0 - initial release
// ============================================================================
module div_16by8_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] c_ones    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_zero_w  = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] c_cnt_top = CNT_W'(WIDTH - 1);

    div_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic [WIDTH-1:0] r_shift;    // dividend low half, becomes the quotient
    logic [WIDTH-1:0] r_div;      // divisor captured at acceptance
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_quot, r_remainder;
    logic             r_dbz, r_ovf;

    logic             w_accept, w_dbz, w_ovf;
    logic [WIDTH:0]   w_t;
    logic [WIDTH-1:0] w_diff, w_rem_nxt, w_shift_nxt;
    logic             w_ge;

    assign w_accept = (r_state == IDLE) && start;
    assign w_dbz    = (divisor == c_zero_w);
    // A high half at or above the divisor yields a quotient wider than WIDTH.
    assign w_ovf    = (dividend[2*WIDTH-1:WIDTH] >= divisor);

    // One restoring step: bring down the next dividend bit and try-subtract.
    assign w_t = {r_rem, r_shift[WIDTH-1]};

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a    (w_t),
        .i_b    ({1'b0, r_div}),
        .o_diff (w_diff),
        .o_ge   (w_ge)
    );

    assign w_rem_nxt   = w_ge ? w_diff : w_t[WIDTH-1:0];
    assign w_shift_nxt = {r_shift[WIDTH-2:0], w_ge};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (w_dbz || w_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_count == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_shift     <= '0;
            r_div       <= '0;
            r_count     <= '0;
            r_quot      <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            if (w_dbz) begin
                // Divide-by-zero wins over overflow (0 <= any high half).
                r_quot      <= c_ones;
                r_remainder <= dividend[WIDTH-1:0];
                r_dbz       <= 1'b1;
                r_ovf       <= 1'b0;
            end else if (w_ovf) begin
                r_quot      <= c_ones;
                r_remainder <= c_zero_w;
                r_dbz       <= 1'b0;
                r_ovf       <= 1'b1;
            end else begin
                r_rem   <= dividend[2*WIDTH-1:WIDTH];
                r_shift <= dividend[WIDTH-1:0];
                r_div   <= divisor;
                r_count <= c_cnt_top;
            end
        end else if (r_state == RUN) begin
            r_rem   <= w_rem_nxt;
            r_shift <= w_shift_nxt;
            if (r_count == '0) begin
                r_quot      <= w_shift_nxt;
                r_remainder <= w_rem_nxt;
                r_dbz       <= 1'b0;
                r_ovf       <= 1'b0;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign ready       = (r_state == IDLE);
    assign done        = (r_state == DONE);
    assign quotient    = r_quot;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule : div_16by8_seq
`default_nettype wire

// File: tb/tb_div_16by8_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_16by8_seq
// Description : Directed self-checking bench for div_16by8_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_16by8_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        ready;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    div_16by8_seq #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request at a falling edge, hold it across one rising edge.
    task automatic launch(input logic [15:0] dd, input logic [7:0] dv);
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count falling edges until done is seen, bounded.
    task automatic wait_done(output int cycles, output bit timeout);
        cycles  = 0;
        timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        total++;
        if ({ready, done} !== 2'b10) begin
            bad++;
            $display("FAIL reset_hs: ready/done=%b expected 10", {ready, done});
        end
        total++;
        if ({quotient, remainder, div_by_zero, overflow} !== 18'd0) begin
            bad++;
            $display("FAIL reset_out: q=%h r=%h dbz=%b ovf=%b expected all 0",
                     quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle: ready=%b expected 1", ready);
        end
    endtask

    task automatic test_normal;
        int cyc;
        bit to;
        launch(16'd1000, 8'd7);
        // Changing inputs after acceptance must not disturb the operation.
        dividend = 16'hFFFF;
        divisor  = 8'h01;
        wait_done(cyc, to);
        total++;
        if (to || cyc != 9) begin
            bad++;
            $display("FAIL normal_latency: cycles=%0d timeout=%0d expected 9", cyc, to);
        end
        total++;
        if (quotient !== 8'd142 || remainder !== 8'd6) begin
            bad++;
            $display("FAIL normal_result: q=%0d r=%0d expected q=142 r=6", quotient, remainder);
        end
        total++;
        if ({div_by_zero, overflow} !== 2'b00) begin
            bad++;
            $display("FAIL normal_flags: dbz/ovf=%b expected 00", {div_by_zero, overflow});
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse: done=%b ready=%b expected 0 1", done, ready);
        end
    endtask

    task automatic test_inverse;
        int cyc;
        bit to;
        launch(16'hFE01, 8'hFF);
        wait_done(cyc, to);
        total++;
        if (to || quotient !== 8'hFF || remainder !== 8'h00 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL inverse: q=%h r=%h ovf=%b to=%0d expected q=ff r=00 ovf=0",
                     quotient, remainder, overflow, to);
        end
    endtask

    task automatic test_overflow;
        int cyc;
        bit to;
        launch(16'h1234, 8'h12);
        wait_done(cyc, to);
        total++;
        if (to || cyc != 1) begin
            bad++;
            $display("FAIL ovf_latency: cycles=%0d timeout=%0d expected 1", cyc, to);
        end
        total++;
        if (quotient !== 8'hFF || remainder !== 8'h00 || overflow !== 1'b1 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL ovf_result: q=%h r=%h ovf=%b dbz=%b expected ff 00 1 0",
                     quotient, remainder, overflow, div_by_zero);
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        bit to;
        launch(16'h00AB, 8'h00);
        wait_done(cyc, to);
        total++;
        if (to || cyc != 1) begin
            bad++;
            $display("FAIL dbz_latency: cycles=%0d timeout=%0d expected 1", cyc, to);
        end
        total++;
        if (quotient !== 8'hFF || remainder !== 8'hAB || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL dbz_result: q=%h r=%h dbz=%b ovf=%b expected ff ab 1 0",
                     quotient, remainder, div_by_zero, overflow);
        end
        repeat (3) @(negedge clk);
        total++;
        if (quotient !== 8'hFF || remainder !== 8'hAB || div_by_zero !== 1'b1) begin
            bad++;
            $display("FAIL dbz_hold: q=%h r=%h dbz=%b expected ff ab 1",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_abort;
        int cyc;
        int done_seen;
        bit to;
        launch(16'd1000, 8'd7);
        @(negedge clk);
        @(negedge clk);
        // RUN cycle 2: a second request must be ignored.
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy: ready=%b expected 0", ready);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // RUN cycle 4: asynchronous abort.
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready, done, quotient, remainder, div_by_zero, overflow} !== {2'b10, 18'd0}) begin
            bad++;
            $display("FAIL abort_reset: ready=%b done=%b q=%h r=%h dbz=%b ovf=%b expected 1 0 00 00 0 0",
                     ready, done, quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        total++;
        if (done_seen != 0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_nodone: done_count=%0d ready=%b expected 0 1", done_seen, ready);
        end
        launch(16'd50, 8'd5);
        wait_done(cyc, to);
        total++;
        if (to || cyc != 9 || quotient !== 8'd10 || remainder !== 8'd0) begin
            bad++;
            $display("FAIL abort_fresh: cycles=%0d q=%0d r=%0d expected 9 10 0", cyc, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit to;
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd0;
        divisor  = 8'd5;
        wait_done(cyc, to);
        total++;
        if (to || quotient !== 8'd0 || remainder !== 8'd0) begin
            bad++;
            $display("FAIL b2b_first: q=%0d r=%0d to=%0d expected 0 0", quotient, remainder, to);
        end
        dividend = 16'd255;
        divisor  = 8'd16;
        wait_done(cyc, to);
        start = 1'b0;
        total++;
        if (to || cyc != 10) begin
            bad++;
            $display("FAIL b2b_spacing: cycles=%0d timeout=%0d expected 10", cyc, to);
        end
        total++;
        if (quotient !== 8'd15 || remainder !== 8'd15) begin
            bad++;
            $display("FAIL b2b_second: q=%0d r=%0d expected 15 15", quotient, remainder);
        end
        repeat (3) @(negedge clk);
        total++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: ready=%b done=%b expected 1 0", ready, done);
        end
    endtask

    initial begin
        test_reset;
        test_normal;
        test_inverse;
        test_overflow;
        test_div_zero;
        test_abort;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_16by8_seq
`default_nettype wire
